mossbauer_velocity_dac: RTL and testbench

- Generates the Mossbauer transducer velocity-drive waveform: a symmetric triangle stepped once per channel, written to the DAC.
- Publishes channel index, channel strobe and frame-start so the acquisition side can bin its smoothed ADC stream against velocity.
- Sits on the DAC side of the signal chain, in the same clock domain as the ADC data processing.

---
 rtl/mossbauer_pkg.sv | 19 +
 rtl/mossbauer_dwell_timer.sv | 23 ++
 rtl/mossbauer_velocity_dac.sv | 102 ++++++++++
 tb/tb_mossbauer_velocity_dac.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mossbauer_pkg.sv
// Shared types and helpers for the Mossbauer velocity-drive DAC.
package mossbauer_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int N_DEFAULT = 1024;
  localparam int CH_W      = $clog2(N_DEFAULT);

  // Clamp a 32-bit accumulator to a dw-bit signed range, result sign-extended.
  function automatic logic signed [31:0] sat_dac(input logic signed [31:0] acc, input int dw);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/mossbauer_dwell_timer.sv
// Per-channel dwell counter; flags the last cycle of each channel.
module mossbauer_dwell_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_dwell,
  output logic        o_last_cycle
);

  logic [31:0] r_cnt;
  logic [31:0] w_lim;

  // A dwell of 0 behaves as 1, so the limit never underflows.
  assign w_lim        = (i_dwell == 32'd0) ? 32'd0 : i_dwell - 32'd1;
  assign o_last_cycle = (r_cnt == w_lim);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_cnt <= '0;
    else if (i_load || o_last_cycle)  r_cnt <= '0;
    else                              r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: rtl/mossbauer_velocity_dac.sv
// Triangle velocity drive for the Mossbauer transducer, one step per channel,
// with channel/frame markers for velocity binning on the acquisition side.
module mossbauer_velocity_dac
  import mossbauer_pkg::*;
#(
  parameter int DAC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int N                = 1024
) (
  input  logic                        adc_clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_dwell,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
  output logic [AXIS_TDATA_WIDTH-1:0] dac_dat,
  output logic [$clog2(N)-1:0]        channel,
  output logic                        chan_strobe,
  output logic                        frame_start,
  output logic [31:0]                 frame_count,
  output logic                        busy
);

  localparam int                 CH_BITS = $clog2(N);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(N - 1);
  localparam logic [CH_BITS-1:0] HALF_CH = CH_BITS'(N / 2);

  state_t              r_state;
  logic [31:0]         r_dwell;
  logic signed [31:0]  r_step;
  logic signed [31:0]  r_acc;

  logic                w_last;
  logic                w_frame_end;
  logic                w_start;
  logic [CH_BITS-1:0]  w_next_ch;
  logic signed [31:0]  w_acc_next;
  logic signed [31:0]  w_cfg_start;

  mossbauer_dwell_timer u_timer (
    .i_clk        (adc_clk),
    .i_rst_n      (aresetn),
    .i_load       (r_state == IDLE),
    .i_dwell      (r_dwell),
    .o_last_cycle (w_last)
  );

  assign w_cfg_start = 32'(cfg_start);
  assign w_frame_end = (r_state == RUN) && w_last && (channel == LAST_CH);
  assign w_start     = enable && ((r_state == IDLE) || w_frame_end);

  // Rising half adds, the first falling channel holds (flat top), then subtract.
  always_comb begin
    w_next_ch  = channel + 1'b1;
    w_acc_next = r_acc;
    if (w_next_ch < HALF_CH)       w_acc_next = r_acc + r_step;
    else if (w_next_ch > HALF_CH)  w_acc_next = r_acc - r_step;
  end

  always_ff @(posedge adc_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_dwell     <= '0;
      r_step      <= '0;
      r_acc       <= '0;
      dac_dat     <= '0;
      channel     <= '0;
      chan_strobe <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      chan_strobe <= 1'b0;
      frame_start <= 1'b0;
      if (w_frame_end) frame_count <= frame_count + 32'd1;

      if (w_start) begin
        // New frame: shadow config is taken from the live inputs right now.
        r_state     <= RUN;
        r_dwell     <= 32'(cfg_dwell);
        r_step      <= 32'(cfg_step);
        r_acc       <= w_cfg_start;
        dac_dat     <= AXIS_TDATA_WIDTH'(sat_dac(w_cfg_start, DAC_WIDTH));
        channel     <= '0;
        chan_strobe <= 1'b1;
        frame_start <= 1'b1;
        busy        <= 1'b1;
      end else if (w_frame_end || (r_state == IDLE)) begin
        r_state <= IDLE;
        dac_dat <= '0;
        channel <= '0;
        busy    <= 1'b0;
      end else if (w_last) begin
        channel     <= w_next_ch;
        chan_strobe <= 1'b1;
        r_acc       <= w_acc_next;
        dac_dat     <= AXIS_TDATA_WIDTH'(sat_dac(w_acc_next, DAC_WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_mossbauer_velocity_dac.sv
// Self-checking bench for mossbauer_velocity_dac with N=8.
module tb_mossbauer_velocity_dac;

  localparam int N = 8;

  logic        adc_clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [31:0] cfg_dwell, cfg_start, cfg_step;
  logic [31:0] dac_dat;
  logic [2:0]  channel;
  logic        chan_strobe, frame_start, busy;
  logic [31:0] frame_count;

  mossbauer_velocity_dac #(.DAC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .N(N)) dut (
    .adc_clk     (adc_clk),
    .aresetn     (aresetn),
    .enable      (enable),
    .cfg_dwell   (cfg_dwell),
    .cfg_start   (cfg_start),
    .cfg_step    (cfg_step),
    .dac_dat     (dac_dat),
    .channel     (channel),
    .chan_strobe (chan_strobe),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    int dac;
    int ch;
    bit stb;
    bit fs;
    bit bsy;
    int fc;
  } exp_t;

  typedef struct {
    int dwell;
    int start;
    int step;
  } vec_t;

  exp_t q[$];
  vec_t tbl[4];
  int   vals_tbl[4][8];
  int   v100[8], v50[8], v_rst[8], v_d1[8];
  int   checks = 0;
  int   errors = 0;

  task automatic push_frame(input int v[8], input int d, input int fc);
    for (int c = 0; c < N; c++)
      for (int k = 0; k < d; k++)
        q.push_back('{v[c], c, (k == 0), (c == 0 && k == 0), 1'b1, fc});
  endtask

  task automatic push_idle(input int n, input int fc);
    for (int i = 0; i < n; i++) q.push_back('{0, 0, 1'b0, 1'b0, 1'b0, fc});
  endtask

  task automatic chk(input string name);
    exp_t e;
    @(negedge adc_clk);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, dut dac=%0d ch=%0d", name, $signed(dac_dat), channel);
    end else begin
      e = q.pop_front();
      if ($signed(dac_dat) != e.dac || int'(channel) != e.ch || chan_strobe != e.stb ||
          frame_start != e.fs || busy != e.bsy || int'(frame_count) != e.fc) begin
        errors++;
        $display("FAIL %s: got dac=%0d ch=%0d stb=%0b fs=%0b busy=%0b fc=%0d, want dac=%0d ch=%0d stb=%0b fs=%0b busy=%0b fc=%0d",
                 name, $signed(dac_dat), channel, chan_strobe, frame_start, busy, frame_count,
                 e.dac, e.ch, e.stb, e.fs, e.bsy, e.fc);
      end
    end
  endtask

  task automatic drain(input string name);
    while (q.size() > 0) chk(name);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (dac_dat != 0 || channel != 0 || chan_strobe || frame_start || busy || frame_count != 0) begin
      errors++;
      $display("FAIL %s: got dac=%0d ch=%0d stb=%0b fs=%0b busy=%0b fc=%0d, want all zero",
               name, $signed(dac_dat), channel, chan_strobe, frame_start, busy, frame_count);
    end
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    enable    = 1'b0;
    cfg_dwell = 0; cfg_start = 0; cfg_step = 0;
    q.delete();
    @(negedge adc_clk);
    @(negedge adc_clk);
    chk_zero("reset_state");
    aresetn = 1'b1;
  endtask

  task automatic set_cfg(input int d, input int s, input int st);
    cfg_dwell = d; cfg_start = s; cfg_step = st;
  endtask

  initial begin
    tbl[0] = '{2, 0, 100};
    tbl[1] = '{1, 8000, 200};
    tbl[2] = '{1, -8000, -300};
    tbl[3] = '{0, 0, 100};
    vals_tbl[0] = '{0, 100, 200, 300, 300, 200, 100, 0};
    vals_tbl[1] = '{8000, 8191, 8191, 8191, 8191, 8191, 8191, 8000};
    vals_tbl[2] = '{-8000, -8192, -8192, -8192, -8192, -8192, -8192, -8000};
    vals_tbl[3] = '{0, 100, 200, 300, 300, 200, 100, 0};
    v100  = '{0, 100, 200, 300, 300, 200, 100, 0};
    v50   = '{0, 50, 100, 150, 150, 100, 50, 0};
    v_rst = '{500, 510, 520, 530, 530, 520, 510, 500};
    v_d1  = '{10, 15, 20, 25, 25, 20, 15, 10};

    // Table: three back-to-back frames per configuration, enable held high.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      set_cfg(tbl[i].dwell, tbl[i].start, tbl[i].step);
      enable = 1'b1;
      for (int f = 0; f < 3; f++)
        push_frame(vals_tbl[i], (tbl[i].dwell == 0) ? 1 : tbl[i].dwell, f);
      drain("table");
    end

    // Enable dropped during channel 3: frame completes, then idle, then restart.
    do_reset();
    set_cfg(2, 0, 100);
    enable = 1'b1;
    push_frame(v100, 2, 0);
    push_idle(3, 1);
    for (int i = 0; i < 6; i++) chk("stop_run");
    enable = 1'b0;
    drain("stop_tail");
    enable = 1'b1;
    push_frame(v100, 2, 1);
    drain("stop_restart");

    // Enable low only on the last cycle of channel N-1: exactly one idle cycle.
    do_reset();
    set_cfg(1, 10, 5);
    enable = 1'b1;
    push_frame(v_d1, 1, 0);
    push_idle(1, 1);
    push_frame(v_d1, 1, 1);
    for (int i = 0; i < 8; i++) chk("blip_run");
    enable = 1'b0;
    chk("blip_idle");
    enable = 1'b1;
    drain("blip_restart");

    // Step changed mid-frame takes effect only at the next frame_start.
    do_reset();
    set_cfg(2, 0, 100);
    enable = 1'b1;
    push_frame(v100, 2, 0);
    push_frame(v50, 2, 1);
    for (int i = 0; i < 5; i++) chk("cfg_old");
    cfg_step = 50;
    drain("cfg_new");

    // Asynchronous reset in the middle of a channel.
    do_reset();
    set_cfg(3, 500, 10);
    enable = 1'b1;
    push_frame(v_rst, 3, 0);
    for (int i = 0; i < 4; i++) chk("arst_run");
    q.delete();
    @(posedge adc_clk);
    #3 aresetn = 1'b0;
    #1 chk_zero("arst_async");
    @(negedge adc_clk);
    enable  = 1'b0;
    aresetn = 1'b1;
    push_idle(3, 0);
    drain("arst_idle");
    enable = 1'b1;
    push_frame(v_rst, 3, 0);
    drain("arst_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
